fir_coef_load_ctrl: RTL and testbench
=====================================

// Module: fir_coef_load_ctrl
// PURPOSE
//  Sequencer for the DUC interpolation FIR coefficient port (load strobe + 16-bit coef word).
//  Holds a NUM_TAPS-deep shadow coefficient bank written by the control path.
//  On a start pulse it streams the whole bank into the filter, one word per cycle, tap NUM_TAPS-1 first.
//  Reports busy/done status and sticky protocol errors; sits in the filter config clock domain.
// PARAMETERS
//  NUM_TAPS   16  number of coefficients per load (filter length L)
//  DW         16  coefficient width
//  AW          4  shadow address width; NUM_TAPS <= 2**AW
// PORTS
//  i_clk             in   1   config clock
//  i_rst             in   1   reset, asynchronous, active-high
//  i_wr_en           in   1   shadow bank write strobe
//  i_wr_addr         in   AW  shadow write address (tap index)
//  i_wr_data         in   DW  shadow write data
//  i_start           in   1   single-cycle request: stream shadow bank to filter
//  i_err_clr         in   1   clears o_err
//  o_busy            out  1   high while state != IDLE
//  o_done            out  1   one-cycle pulse after the last word is issued
//  o_err             out  1   sticky protocol error flag
//  o_load_parameter  out  1   coefficient load strobe to filter
//  o_parameter_data  out  DW  coefficient word to filter, valid when o_load_parameter=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, tap counter 0, shadow bank all zeros. Reset mid-load aborts immediately; no o_done.
//  FSM: IDLE -(i_start)-> LOAD -(counter==0 issued)-> DONE -(1 cycle)-> IDLE.
//  - i_start sampled at edge t in IDLE: counter <= NUM_TAPS-1, state <= LOAD.
//  - LOAD: every cycle, o_load_parameter=1 and o_parameter_data=shadow[counter] (registered outputs).
//    The counter decrements; words appear on cycles t+1 .. t+NUM_TAPS, in order shadow[NUM_TAPS-1] .. shadow[0].
//  - DONE: o_load_parameter=0, o_parameter_data=0, o_done=1 on cycle t+NUM_TAPS+1. IDLE on t+NUM_TAPS+2.
//  - Strobe is contiguous, with no gaps. Outside LOAD, o_load_parameter=0 and o_parameter_data=0.
//  Writes: accepted only in IDLE with i_start=0 and i_wr_addr < NUM_TAPS. The shadow is updated at that edge.
//  Error conditions (each sets o_err at the same edge; the offending request is dropped):
//  - i_wr_en while o_busy=1 (bank is frozen during a load).
//  - i_wr_en with i_wr_addr >= NUM_TAPS.
//  - i_start while o_busy=1 (no restart/queue; the current load continues unchanged).
//  - i_wr_en and i_start in the same IDLE cycle: start wins, the write is dropped.
//  o_err: i_err_clr clears it. If set and clear coincide, set wins. Error detection does not affect the FSM.
//  No arithmetic on data; words pass through unmodified at DW bits.
// CONFIGURATION
//  COEF_CHECKSUM_EN defined:
//  - Adds port o_checksum (out, DW): modulo-2**DW sum of all words issued in the last completed load.
//  - Accumulator clears on entry to LOAD and adds each issued word.
//  - o_checksum updates at the edge o_done rises and holds until the next o_done.
//  - Reset value 0. A load aborted by reset does not update it.
//  COEF_CHECKSUM_EN undefined: no o_checksum port and no accumulator logic; all other behaviour identical.
// TESTING
//  T1: reset; i_start without writes -> 16 strobes, all data 0x0000; o_done on cycle 17 after start; o_err=0.
//  T2: write shadow[k]=0x1000+k, k=0..15; start -> data 0x100F,0x100E..0x1000 on cycles t+1..t+16; o_busy high t+1..t+17.
//  T3: during T2 load: i_wr_en addr 3 and a second i_start -> o_err=1, shadow[3] unchanged in next load, exactly 16 strobes.
//  T4: i_wr_en addr 5 and i_start same cycle -> load streams old shadow[5], o_err=1; i_err_clr -> o_err=0 next cycle.
//  T5: assert i_rst at 8th strobe -> outputs 0 at once, no o_done; the next start streams all-zero bank.
//  T6 (COEF_CHECKSUM_EN): T2 bank -> o_checksum=0x0078 at o_done (16*0x1000 wraps to 0, +0..15=0x78).

Source files
------------

// File: rtl/fir_coef_load_ctrl.sv
// -----------------------------------------------------------------------------
// fir_coef_load_ctrl
//
// Purpose:
//   Coefficient-port sequencer for the DUC interpolation FIR. The control path
//   writes a NUM_TAPS-deep shadow coefficient bank. A single-cycle start request
//   streams the whole bank into the filter, one word per cycle, highest tap
//   first. Busy/done status and a sticky protocol-error flag are reported.
//   Lives entirely in the filter configuration clock domain.
//
// Optional feature (macro COEF_CHECKSUM_EN):
//   When defined, adds o_checksum: the modulo-2**DW sum of every word issued
//   in the last completed load. It updates on the edge where o_done rises.
//   When undefined, neither the port nor the accumulator exists.
//
// Ports:
//   i_clk             config clock
//   i_rst             asynchronous, active-high reset
//   i_wr_en           shadow bank write strobe
//   i_wr_addr   [AW]  shadow write address (tap index)
//   i_wr_data   [DW]  shadow write data
//   i_start           single-cycle request to stream the bank to the filter
//   i_err_clr         clears o_err (a coincident new error wins)
//   o_busy            high while the sequencer is not idle
//   o_done            one-cycle pulse after the last word has been issued
//   o_err             sticky protocol error flag
//   o_load_parameter  coefficient load strobe to the filter
//   o_parameter_data  [DW] coefficient word, valid while o_load_parameter=1
//   o_checksum  [DW]  (COEF_CHECKSUM_EN only) sum of the last completed load
//   o_dbg_state [2]   current FSM state, for debug and checker binding
//
// Handshake: the filter port is valid-only (no ready / backpressure). Every
// cycle with o_load_parameter=1 transfers exactly one word in o_parameter_data;
// the strobe is contiguous for NUM_TAPS cycles and data is forced to zero
// whenever the strobe is low.
// -----------------------------------------------------------------------------
module fir_coef_load_ctrl #(
    parameter int NUM_TAPS = 16,
    parameter int DW       = 16,
    parameter int AW       = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_start,
    input  logic          i_err_clr,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_load_parameter,
    output logic [DW-1:0] o_parameter_data,
`ifdef COEF_CHECKSUM_EN
    output logic [DW-1:0] o_checksum,
`endif
    output logic [1:0]    o_dbg_state
);

    // Tap count and last tap index expressed at the address widths so that
    // comparisons and indexing stay width-exact.
    localparam logic [AW:0]   TAPS_EXT = (AW+1)'(NUM_TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] cnt_dec;
    logic          load_q, load_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [DW-1:0] shadow_q [NUM_TAPS];

    logic          idle;
    logic          addr_ok;
    logic          wr_accept;
    logic          err_set;

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    assign idle    = (state_q == ST_IDLE);
    assign addr_ok = ({1'b0, i_wr_addr} < TAPS_EXT);

    // The bank is frozen for the whole load; a start in the same idle cycle as
    // a write takes priority and the write is discarded.
    assign wr_accept = i_wr_en && idle && !i_start && addr_ok;

    assign err_set = (i_wr_en && !idle)
                   || (i_wr_en && !addr_ok)
                   || (i_start && !idle)
                   || (i_wr_en && i_start && idle);

    assign cnt_dec = cnt_q - 1'b1;

    // -------------------------------------------------------------------------
    // FSM state register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    //
    // The outputs are registered, so the word for the following cycle is
    // fetched here: the start edge already presents shadow[NUM_TAPS-1], and
    // each LOAD edge presents shadow[counter-1] as the counter steps down.
    // When the counter reaches 0 its word is on the port this cycle, so the
    // next edge moves to DONE and raises o_done.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        data_d  = '0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = LAST_TAP;
                    load_d  = 1'b1;
                    data_d  = shadow_q[LAST_TAP];
                end
            end
            ST_LOAD: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_dec;
                    load_d = 1'b1;
                    data_d = shadow_q[cnt_dec];
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky error: a new error in the same cycle as a clear keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow coefficient bank
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_accept) begin
            shadow_q[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef COEF_CHECKSUM_EN
    // -------------------------------------------------------------------------
    // Load checksum
    //
    // data_q holds the word being issued in each LOAD cycle, so summing it
    // there covers every word exactly once. The final word is folded in on the
    // edge into DONE, which is also the edge o_done rises.
    // -------------------------------------------------------------------------
    logic [DW-1:0] acc_q;
    logic [DW-1:0] chk_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
            chk_q <= '0;
        end else begin
            if (idle && i_start) begin
                acc_q <= '0;
            end else if (state_q == ST_LOAD) begin
                acc_q <= acc_q + data_q;
            end

            if ((state_q == ST_LOAD) && (cnt_q == '0)) begin
                chk_q <= acc_q + data_q;
            end
        end
    end

    assign o_checksum = chk_q;
`endif

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign o_busy           = !idle;
    assign o_done           = done_q;
    assign o_err            = err_q;
    assign o_load_parameter = load_q;
    assign o_parameter_data = data_q;
    assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_fir_coef_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_load_ctrl
//
// Directed plus randomized bench for fir_coef_load_ctrl. A behavioural model
// of the shadow bank (a plain array), the sticky error flag and the load
// checksum predicts every streamed word; expected words are queued in exp_q
// in issue order (highest tap first).
// -----------------------------------------------------------------------------
module tb_fir_coef_load_ctrl;

    localparam int NT = 16;
    localparam int DW = 16;
    localparam int AW = 4;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_start;
    logic          i_err_clr;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic          o_load_parameter;
    logic [DW-1:0] o_parameter_data;
`ifdef COEF_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif
    logic [1:0]    o_dbg_state;

    always #5 i_clk = ~i_clk;

    fir_coef_load_ctrl #(
        .NUM_TAPS (NT),
        .DW       (DW),
        .AW       (AW)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_wr_en          (i_wr_en),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .i_start          (i_start),
        .i_err_clr        (i_err_clr),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_load_parameter (o_load_parameter),
        .o_parameter_data (o_parameter_data),
`ifdef COEF_CHECKSUM_EN
        .o_checksum       (o_checksum),
`endif
        .o_dbg_state      (o_dbg_state)
    );

    // -------------------------------------------------------------------------
    // Reference model and scoreboard
    // -------------------------------------------------------------------------
    logic [DW-1:0] mdl_bank [NT];
    logic          mdl_err;
    logic [DW-1:0] mdl_chk;
    logic [DW-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < NT; k++) mdl_bank[k] = '0;
        mdl_err = 1'b0;
        mdl_chk = '0;
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge, outputs
    // are sampled at the same point)
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        tick();
        i_wr_en   = 1'b0;
        mdl_bank[a] = d;
    endtask

    task automatic clear_err();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        mdl_err   = 1'b0;
    endtask

    // Start a load from IDLE and check every cycle of it.
    //   inject     : 1..NT -> during that strobe cycle also request a write to
    //                tap 3 and a second start (both must be rejected)
    //   same_wr    : a write to tap 5 accompanies the start request
    //   clr_at_err : i_err_clr is asserted together with same_wr
    task automatic run_load(input string tag, input int inject, input bit same_wr,
                            input bit clr_at_err);
        logic [DW-1:0] sum;
        exp_q.delete();
        sum = '0;
        for (int k = NT - 1; k >= 0; k--) begin
            exp_q.push_back(mdl_bank[k]);
            sum = sum + mdl_bank[k];
        end

        chk($sformatf("%s idle strobe", tag), 32'(o_load_parameter), 32'd0);
        i_start = 1'b1;
        if (same_wr) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 4'd5;
            i_wr_data = ~mdl_bank[5];
            i_err_clr = clr_at_err;
            mdl_err   = 1'b1;
        end
        tick();
        i_start   = 1'b0;
        i_wr_en   = 1'b0;
        i_err_clr = 1'b0;

        for (int c = 1; c <= NT; c++) begin
            chk($sformatf("%s strobe c%0d", tag, c), 32'(o_load_parameter), 32'd1);
            chk($sformatf("%s data c%0d", tag, c), 32'(o_parameter_data), 32'(exp_q.pop_front()));
            chk($sformatf("%s done c%0d", tag, c), 32'(o_done), 32'd0);
            chk($sformatf("%s busy c%0d", tag, c), 32'(o_busy), 32'd1);
            if (c == inject) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 4'd3;
                i_wr_data = ~mdl_bank[3];
                i_start   = 1'b1;
                mdl_err   = 1'b1;
            end
            tick();
            i_wr_en = 1'b0;
            i_start = 1'b0;
        end

        chk($sformatf("%s strobe after", tag), 32'(o_load_parameter), 32'd0);
        chk($sformatf("%s data after", tag), 32'(o_parameter_data), 32'd0);
        chk($sformatf("%s done pulse", tag), 32'(o_done), 32'd1);
        chk($sformatf("%s busy in done", tag), 32'(o_busy), 32'd1);
`ifdef COEF_CHECKSUM_EN
        mdl_chk = sum;
        chk($sformatf("%s checksum", tag), 32'(o_checksum), 32'(mdl_chk));
`endif
        tick();
        chk($sformatf("%s done low", tag), 32'(o_done), 32'd0);
        chk($sformatf("%s busy low", tag), 32'(o_busy), 32'd0);
        chk($sformatf("%s err", tag), 32'(o_err), 32'(mdl_err));
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bit            seen_done;
        int            n_wr;

        i_rst     = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_start   = 1'b0;
        i_err_clr = 1'b0;
        mdl_reset();

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst done", 32'(o_done), 32'd0);
        chk("rst err", 32'(o_err), 32'd0);
        chk("rst strobe", 32'(o_load_parameter), 32'd0);
        chk("rst data", 32'(o_parameter_data), 32'd0);
`ifdef COEF_CHECKSUM_EN
        chk("rst checksum", 32'(o_checksum), 32'd0);
`endif
        i_rst = 1'b0;
        tick();

        // T1: load from a never-written bank
        run_load("T1", 0, 1'b0, 1'b0);

        // T2: ramp bank 0x1000+k
        for (int k = 0; k < NT; k++) do_write(AW'(k), 16'h1000 + 16'(k));
        chk("T2 bank top", 32'(mdl_bank[NT-1]), 32'h100F);
        run_load("T2", 0, 1'b0, 1'b0);
`ifdef COEF_CHECKSUM_EN
        chk("T6 checksum const", 32'(o_checksum), 32'h0078);
`endif

        // T3: write + restart during a load are rejected; bank unchanged
        run_load("T3", 6, 1'b0, 1'b0);
        chk("T3 err sticky", 32'(o_err), 32'd1);
        clear_err();
        chk("T3 err cleared", 32'(o_err), 32'd0);
        run_load("T3 reload", 0, 1'b0, 1'b0);

        // T4: write + start in the same idle cycle, with a coincident clear
        run_load("T4", 0, 1'b1, 1'b1);
        chk("T4 err set wins", 32'(o_err), 32'd1);
        clear_err();
        chk("T4 err cleared", 32'(o_err), 32'd0);

        // Randomized banks, some loads with a mid-load protocol violation
        for (int it = 0; it < 4; it++) begin
            n_wr = $urandom_range(4, 14);
            for (int w = 0; w < n_wr; w++) begin
                do_write(AW'($urandom_range(0, NT - 1)), DW'($urandom));
            end
            chk($sformatf("R%0d err before", it), 32'(o_err), 32'(mdl_err));
            run_load($sformatf("R%0d", it), (it % 2 == 1) ? $urandom_range(1, NT) : 0,
                     1'b0, 1'b0);
            clear_err();
            chk($sformatf("R%0d err cleared", it), 32'(o_err), 32'd0);
        end

        // T5: reset during the 8th strobe
        for (int k = 0; k < NT; k++) do_write(AW'(k), DW'($urandom_range(1, 16'hFFFF)));
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk("T5 8th strobe", 32'(o_load_parameter), 32'd1);
        i_rst = 1'b1;
        #1;
        mdl_reset();
        chk("T5 rst strobe", 32'(o_load_parameter), 32'd0);
        chk("T5 rst data", 32'(o_parameter_data), 32'd0);
        chk("T5 rst busy", 32'(o_busy), 32'd0);
        chk("T5 rst done", 32'(o_done), 32'd0);
        chk("T5 rst err", 32'(o_err), 32'd0);
        tick();
        i_rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_done === 1'b1 || o_load_parameter === 1'b1) seen_done = 1'b1;
        end
        chk("T5 no done after abort", 32'(seen_done), 32'd0);
`ifdef COEF_CHECKSUM_EN
        chk("T5 checksum after abort", 32'(o_checksum), 32'd0);
`endif
        run_load("T5 zero bank", 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
